pipe_hazard_ctrl: RTL

Central pipeline controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB). It consumes the decoded register indices and flags of the instruction currently in ID, plus branch redirects from EX. From these it drives:
- stall, flush and bubble controls for the pipeline registers;
- operand forwarding selects for EX;
- multi-cycle EX sequencing for the carry-less multiply ops;
- a trap FSM for illegal instructions.

It keeps its own shadow copy of the destination registers of EX/MEM/WB, so it needs no datapath feedback other than the redirect.

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/mc_sequencer.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the RV32 pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2,
        HALT  = 2'd3
    } trap_state_t;

    // Shadow copy of one pipeline stage's destination
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } shadow_t;

    localparam shadow_t SHADOW_NOP = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};

    // A source depends on a stage only if it reads a real register that stage writes
    function automatic logic src_hit(input logic [4:0] rs, input shadow_t e);
        return (rs != 5'd0) && e.valid && (e.rd == rs);
    endfunction

    // Youngest producer wins: MEM before WB
    function automatic fwd_sel_t fwd_pick(input logic [4:0] rs, input shadow_t mem,
                                          input shadow_t wb);
        if (src_hit(rs, mem))
            return FWD_MEM;
        else if (src_hit(rs, wb))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Multi-cycle EX sequencer for the clmul family: counts the extra EX cycles
// and freezes EX / starves MEM while the op is still computing.
module mc_sequencer #(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_start,
    output logic o_hold,
    output logic o_bubble_mem
);

    logic [3:0] r_cnt;

    // Load on entry to EX, then count down to the cycle the result leaves
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_cnt <= 4'd0;
        else if (i_start)
            r_cnt <= 4'(MC_LAT - 1);
        else if (r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
    end

    assign o_hold       = (r_cnt != 4'd0);
    assign o_bubble_mem = o_hold;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forward/trap controller for the 5-stage RV32 pipe.
// Optional build macro FWD_BYPASS_EN: when defined, EX operands are
// forwarded from MEM/WB and only load-use stalls; when undefined, forward
// selects stay at the regfile and any RAW hazard stalls until it retires.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LAT     = 4,
    parameter int TRAP_DRAIN = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_is_load,
    input  logic       id_mc,
    input  logic       id_ill,
    input  logic       ex_redirect,
    input  logic       trap_ack,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_id,
    output logic       bubble_ex,
    output logic       hold_ex,
    output logic       bubble_mem,
    output logic [1:0] fwd_rs1,
    output logic [1:0] fwd_rs2,
    output logic       trap,
    output logic       halted
);

    logic        r_init;
    logic        w_en;
    logic        w_id_valid;
    logic        w_redirect;
    logic        w_ack;
    shadow_t     r_ex;
    shadow_t     r_mem;
    shadow_t     r_wb;
    logic [4:0]  r_ex_rs1;
    logic [4:0]  r_ex_rs2;
    trap_state_t r_state;
    trap_state_t w_state_nxt;
    logic [1:0]  r_tcnt;
    logic [1:0]  w_tcnt_nxt;
    logic        w_hold;
    logic        w_bubble_mem;
    logic        w_match;
    logic        w_haz;
    logic        w_mc_start;
    logic        w_fsm_stall_if;
    logic        w_fsm_stall_id;
    logic        w_fsm_bubble;
    logic        w_fsm_flush;
    logic        w_trap;
    logic        w_halted;
    logic        w_stall_if;
    logic        w_stall_id;
    logic        w_bubble_ex;
    logic        w_flush_id;
    fwd_sel_t    w_fwd1;
    fwd_sel_t    w_fwd2;
    logic        w_unused;

    // Outputs stay quiet for the reset cycle and the one after it
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_init <= 1'b0;
        else
            r_init <= 1'b1;
    end

    assign w_en       = reset_n & r_init;
    assign w_id_valid = id_valid & w_en;
    assign w_redirect = ex_redirect & w_en;
    assign w_ack      = trap_ack & w_en;

`ifdef FWD_BYPASS_EN
    // Only a load still in EX cannot be bypassed in time
    assign w_match = r_ex.is_load & (src_hit(id_rs1, r_ex) | src_hit(id_rs2, r_ex));
    assign w_fwd1  = fwd_pick(r_ex_rs1, r_mem, r_wb);
    assign w_fwd2  = fwd_pick(r_ex_rs2, r_mem, r_wb);
    assign w_unused = ^{r_mem.is_load, r_wb.is_load};
`else
    // No bypass network: wait until the producer has left WB
    assign w_match = src_hit(id_rs1, r_ex) | src_hit(id_rs2, r_ex) |
                     src_hit(id_rs1, r_mem) | src_hit(id_rs2, r_mem) |
                     src_hit(id_rs1, r_wb) | src_hit(id_rs2, r_wb);
    assign w_fwd1  = FWD_RF;
    assign w_fwd2  = FWD_RF;
    assign w_unused = ^{r_mem.is_load, r_wb.is_load, r_ex.is_load, r_ex_rs1, r_ex_rs2};
`endif

    // Redirect squashes the consumer, and a held EX already stalls the front
    assign w_haz = (r_state == RUN) & w_id_valid & ~w_redirect & ~w_hold & w_match;

    // Trap FSM state and drain counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_tcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // Trap FSM next state and front-end controls
    always_comb begin
        w_state_nxt    = r_state;
        w_tcnt_nxt     = r_tcnt;
        w_fsm_stall_if = 1'b0;
        w_fsm_stall_id = 1'b0;
        w_fsm_bubble   = 1'b0;
        w_fsm_flush    = 1'b0;
        w_trap         = 1'b0;
        w_halted       = 1'b0;
        case (r_state)
            RUN: begin
                // Illegal op becomes a bubble; stalls take precedence and retry it
                if (w_id_valid & id_ill & ~w_redirect & ~w_haz & ~w_hold) begin
                    w_fsm_stall_if = 1'b1;
                    w_fsm_stall_id = 1'b1;
                    w_fsm_bubble   = 1'b1;
                    w_tcnt_nxt     = 2'(TRAP_DRAIN);
                    w_state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                if (w_redirect) begin
                    // An older branch makes the illegal op dead
                    w_tcnt_nxt  = 2'd0;
                    w_state_nxt = RUN;
                end else begin
                    w_fsm_stall_if = 1'b1;
                    w_fsm_stall_id = 1'b1;
                    w_fsm_bubble   = 1'b1;
                    w_tcnt_nxt     = r_tcnt - 2'd1;
                    if (r_tcnt <= 2'd1)
                        w_state_nxt = TRAP;
                end
            end
            TRAP: begin
                // Squash the illegal op sitting in ID instead of letting it into EX
                w_trap         = 1'b1;
                w_fsm_flush    = 1'b1;
                w_fsm_stall_if = 1'b1;
                w_fsm_bubble   = 1'b1;
                w_tcnt_nxt     = 2'd0;
                w_state_nxt    = HALT;
            end
            HALT: begin
                w_halted       = 1'b1;
                w_fsm_stall_if = 1'b1;
                w_fsm_flush    = 1'b1;
                if (w_ack)
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_stall_if  = w_hold | w_haz | w_fsm_stall_if;
    assign w_stall_id  = w_hold | w_haz | w_fsm_stall_id;
    assign w_bubble_ex = w_redirect | w_haz | w_fsm_bubble;
    assign w_flush_id  = w_redirect | w_fsm_flush;
    assign w_mc_start  = w_id_valid & id_mc & ~w_stall_id & ~w_bubble_ex;

    mc_sequencer #(
        .MC_LAT (MC_LAT)
    ) u_mc_seq (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (w_mc_start),
        .o_hold       (w_hold),
        .o_bubble_mem (w_bubble_mem)
    );

    // Shadow EX/MEM/WB destinations; a held EX keeps its entry and starves MEM
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ex     <= SHADOW_NOP;
            r_mem    <= SHADOW_NOP;
            r_wb     <= SHADOW_NOP;
            r_ex_rs1 <= 5'd0;
            r_ex_rs2 <= 5'd0;
        end else begin
            r_wb <= r_mem;
            if (w_hold) begin
                r_mem <= SHADOW_NOP;
            end else begin
                r_mem <= r_ex;
                if (w_bubble_ex) begin
                    r_ex     <= SHADOW_NOP;
                    r_ex_rs1 <= 5'd0;
                    r_ex_rs2 <= 5'd0;
                end else begin
                    r_ex     <= '{valid: w_id_valid, rd: id_rd, is_load: id_is_load};
                    r_ex_rs1 <= w_id_valid ? id_rs1 : 5'd0;
                    r_ex_rs2 <= w_id_valid ? id_rs2 : 5'd0;
                end
            end
        end
    end

    assign stall_if   = w_en & w_stall_if;
    assign stall_id   = w_en & w_stall_id;
    assign flush_id   = w_en & w_flush_id;
    assign bubble_ex  = w_en & w_bubble_ex;
    assign hold_ex    = w_en & w_hold;
    assign bubble_mem = w_en & w_bubble_mem;
    assign fwd_rs1    = w_en ? w_fwd1 : FWD_RF;
    assign fwd_rs2    = w_en ? w_fwd2 : FWD_RF;
    assign trap       = w_en & w_trap;
    assign halted     = w_en & w_halted;

endmodule
